// File: rtl/iter_csa_multiplier_pkg.sv
// rv32i_types: shared multiply op encodings, FSM states and cycle count
package rv32i_types;
    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_t;
    typedef enum logic [1:0] {IDLE, MULT, RESOLVE, DONE} mul_state_t;
    localparam int MUL_CYCLES = 32;
endpackage

// File: rtl/iter_csa_multiplier_csa_row.sv
// csa_row: W-bit 3:2 compressor built from per-bit full adders
// Ports: a, b, c - addends; s - bitwise sum; co - unshifted carries
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module csa_row #(
    parameter int W = 64
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] s,
    output logic [W-1:0] co
);
    for (genvar i = 0; i < W; i++) begin : g_fa
        full_adder u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(s[i]), .co(co[i]));
    end
endmodule

// File: rtl/iter_csa_multiplier.sv
// iter_csa_multiplier: iterative carry-save RV32M multiplier (MUL/MULH/MULHSU/MULHU)
// Ports: clk, rst_n (async low); flush kills in-flight op;
//        in_valid/in_ready/in_op/in_rs1/in_rs2/in_tag request side;
//        out_valid/out_ready/out_result/out_tag result side
module iter_csa_multiplier
    import rv32i_types::*;
#(
    parameter int ROB_IDX_W = 5,
    parameter int XLEN      = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  mul_op_t              in_op,
    input  logic [XLEN-1:0]      in_rs1,
    input  logic [XLEN-1:0]      in_rs2,
    input  logic [ROB_IDX_W-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_result,
    output logic [ROB_IDX_W-1:0] out_tag
);
    localparam int CNT_W = $clog2(MUL_CYCLES);

    mul_state_t            r_state, w_state_next;
    mul_op_t               r_op;
    logic [ROB_IDX_W-1:0]  r_tag;
    logic [XLEN-1:0]       r_mag1, r_mag2, r_out_result;
    logic                  r_neg;
    logic [2*XLEN-1:0]     r_sum, r_carry;
    logic [CNT_W-1:0]      r_count;

    logic                  w_accept, w_s1, w_s2;
    logic [2*XLEN-1:0]     w_pp, w_s, w_c, w_p, w_pn;

    assign in_ready   = (r_state == IDLE) & ~flush;
    assign w_accept   = in_valid & in_ready;
    assign out_valid  = (r_state == DONE);
    assign out_result = r_out_result;
    assign out_tag    = r_tag;

    assign w_s1 = in_rs1[XLEN-1] & ((in_op == MULH) | (in_op == MULHSU));
    assign w_s2 = in_rs2[XLEN-1] & (in_op == MULH);

    assign w_pp = r_mag2[r_count] ? ({{XLEN{1'b0}}, r_mag1} << r_count) : '0;

    csa_row #(.W(2*XLEN)) u_csa (.a(r_sum), .b(r_carry), .c(w_pp), .s(w_s), .co(w_c));

    assign w_p  = r_sum + r_carry;
    assign w_pn = r_neg ? -w_p : w_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    w_state_next = w_accept ? MULT : IDLE;
            MULT:    w_state_next = (r_count == CNT_W'(MUL_CYCLES - 1)) ? RESOLVE : MULT;
            RESOLVE: w_state_next = DONE;
            DONE:    w_state_next = out_ready ? IDLE : DONE;
            default: w_state_next = IDLE;
        endcase
        // flush outranks every transition outside IDLE, including the DONE handshake
        if (flush && r_state != IDLE) w_state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op         <= MUL;
            r_tag        <= '0;
            r_mag1       <= '0;
            r_mag2       <= '0;
            r_neg        <= 1'b0;
            r_sum        <= '0;
            r_carry      <= '0;
            r_count      <= '0;
            r_out_result <= '0;
        end else begin
            if (w_accept) begin
                r_op    <= in_op;
                r_tag   <= in_tag;
                r_mag1  <= w_s1 ? -in_rs1 : in_rs1;
                r_mag2  <= w_s2 ? -in_rs2 : in_rs2;
                r_neg   <= w_s1 ^ w_s2;
                r_sum   <= '0;
                r_carry <= '0;
                r_count <= '0;
            end
            if (r_state == MULT) begin
                r_sum   <= w_s;
                r_carry <= {w_c[2*XLEN-2:0], 1'b0};
                r_count <= r_count + 1'b1;
            end
            if (r_state == RESOLVE && !flush)
                r_out_result <= (r_op == MUL) ? w_pn[XLEN-1:0] : w_pn[2*XLEN-1:XLEN];
        end
    end
endmodule

// File: tb/tb_iter_csa_multiplier.sv
// tb_iter_csa_multiplier: table-driven + scoreboard bench for iter_csa_multiplier
module tb_iter_csa_multiplier;
    import rv32i_types::*;

    logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 1;
    logic        in_ready, out_valid;
    mul_op_t     in_op = MUL;
    logic [31:0] in_rs1 = 0, in_rs2 = 0, out_result;
    logic [4:0]  in_tag = 0, out_tag;
    int          pass_cnt = 0, total_cnt = 0;

    typedef struct {logic [31:0] res; logic [4:0] tag;} sb_t;
    typedef struct {mul_op_t op; logic [31:0] a, b; logic [4:0] tag; logic [31:0] exp;} vec_t;
    sb_t  sbq[$];
    vec_t vt[6];

    iter_csa_multiplier #(.ROB_IDX_W(5), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] model(mul_op_t op, logic [31:0] a, logic [31:0] b);
        logic [63:0] x, y, p;
        x = (op == MULH || op == MULHSU) ? {{32{a[31]}}, a} : {32'b0, a};
        y = (op == MULH) ? {{32{b[31]}}, b} : {32'b0, b};
        p = x * y;
        return (op == MUL) ? p[31:0] : p[63:32];
    endfunction

    task automatic issue(string name, mul_op_t op, logic [31:0] a, logic [31:0] b,
                         logic [4:0] tag, logic [31:0] exp);
        @(negedge clk);
        in_valid = 1; in_op = op; in_rs1 = a; in_rs2 = b; in_tag = tag;
        #1 chk({name, "_in_ready"}, in_ready, 1);
        @(posedge clk);
        sbq.push_back('{exp, tag});
        @(negedge clk);
        in_valid = 0; in_rs1 = $urandom; in_rs2 = $urandom; in_tag = 5'($urandom);
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic collect(string name);
        sb_t e;
        chk({name, "_valid"}, out_valid, 1);
        if (sbq.size() == 0) begin
            chk({name, "_sb_nonempty"}, 0, 1);
        end else begin
            e = sbq.pop_front();
            chk({name, "_result"}, out_result, e.res);
            chk({name, "_tag"}, out_tag, e.tag);
        end
    endtask

    task automatic quiet(string name, int cycles);
        int seen = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk({name, "_no_out"}, seen, 0);
    endtask

    task automatic do_op(string name, mul_op_t op, logic [31:0] a, logic [31:0] b,
                         logic [4:0] tag, logic [31:0] exp);
        int n;
        issue(name, op, a, b, tag, exp);
        wait_out(n);
        chk({name, "_latency"}, n, 33);
        collect(name);
        @(negedge clk);
        chk({name, "_valid_drop"}, out_valid, 0);
        chk({name, "_ready_back"}, in_ready, 1);
    endtask

    initial begin
        int n;
        vt[0] = '{MUL,    32'd7,        32'd6,        5'd3,  32'd42};
        vt[1] = '{MULH,   32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000};
        vt[2] = '{MULH,   32'hFFFF_FFFF, 32'd1,        5'd5,  32'hFFFF_FFFF};
        vt[3] = '{MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFF};
        vt[4] = '{MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE};
        vt[5] = '{MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'h0000_0001};

        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_tag", out_tag, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        #1 chk("rst_in_ready", in_ready, 1);

        foreach (vt[i]) do_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].tag, vt[i].exp);

        for (int i = 0; i < 8; i++) begin
            mul_op_t op;
            logic [31:0] a, b;
            op = mul_op_t'($urandom_range(3, 0));
            a = $urandom;
            b = $urandom;
            do_op($sformatf("rnd%0d", i), op, a, b, 5'(i + 16), model(op, a, b));
        end

        // backpressure: result must hold while the CDB arbiter stalls
        out_ready = 0;
        issue("bp", MUL, 32'd3, 32'd5, 5'd2, 32'd15);
        wait_out(n);
        chk("bp_latency", n, 33);
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_result", out_result, 15);
            chk("bp_hold_in_ready", in_ready, 0);
        end
        out_ready = 1;
        collect("bp");
        @(negedge clk);
        chk("bp_valid_drop", out_valid, 0);
        do_op("bp_next", MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd9, model(MULHU, 32'h1234_5678, 32'h9ABC_DEF0));

        // flush on MULT cycle 10
        issue("fl", MUL, 32'd9, 32'd9, 5'd1, 32'd81);
        repeat (10) @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        void'(sbq.pop_back());
        #1 chk("fl_in_ready", in_ready, 1);
        quiet("fl", 40);
        do_op("fl_next", MUL, 32'd2, 32'd2, 5'd10, 32'd4);

        // flush wins over out_ready in DONE
        out_ready = 0;
        issue("fd", MUL, 32'd11, 32'd3, 5'd11, 32'd33);
        wait_out(n);
        flush = 1; out_ready = 1;
        @(negedge clk);
        flush = 0;
        void'(sbq.pop_back());
        chk("fd_dropped", out_valid, 0);
        quiet("fd", 40);

        // async reset during RESOLVE
        issue("rs", MULHU, 32'hFFFF_FFFF, 32'd3, 5'd12, 32'd2);
        repeat (32) @(negedge clk);
        rst_n = 0;
        #1;
        chk("rs_out_valid", out_valid, 0);
        chk("rs_out_result", out_result, 0);
        chk("rs_out_tag", out_tag, 0);
        @(negedge clk);
        rst_n = 1;
        void'(sbq.pop_back());
        quiet("rs", 40);
        chk("rs_in_ready", in_ready, 1);

        // flush with in_valid in IDLE must not accept
        @(negedge clk);
        flush = 1; in_valid = 1; in_op = MUL; in_rs1 = 5; in_rs2 = 5; in_tag = 13;
        #1 chk("fi_in_ready", in_ready, 0);
        @(negedge clk);
        flush = 0; in_valid = 0;
        #1 chk("fi_not_accepted", in_ready, 1);
        quiet("fi", 40);

        chk("sb_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
